// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between WB (fixed priority) and a buffered MDU.
// Optional macro RF_ARB_BYPASS_EN: an MDU result is written straight through when the FIFO is empty and WB is idle.
module rf_write_arbiter #(
  parameter int WORD_LEN = 32,
  parameter int ADDR_LEN = 5,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_en,
  input  logic [ADDR_LEN-1:0]       wb_dest,
  input  logic [WORD_LEN-1:0]       wb_val,
  input  logic                      mdu_valid,
  input  logic [ADDR_LEN-1:0]       mdu_dest,
  input  logic [WORD_LEN-1:0]       mdu_val,
  output logic                      mdu_ready,
  input  logic [ADDR_LEN-1:0]       src1,
  input  logic [ADDR_LEN-1:0]       src2,
  output logic                      hazard1,
  output logic                      hazard2,
  output logic                      pipe_stall,
  output logic                      wr_en,
  output logic [ADDR_LEN-1:0]       wr_dest,
  output logic [WORD_LEN-1:0]       wr_val,
  output logic [$clog2(DEPTH):0]    buf_count
);
  // state  | meaning
  // IDLE   | FIFO empty
  // QUEUED | entries buffered, waiting for an idle port cycle
  // DRAIN  | FIFO starved: stall the pipeline and force one pop
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, QUEUED, DRAIN} state_t;

  state_t              state;
  logic [ADDR_LEN-1:0] q_dest [DEPTH];
  logic [WORD_LEN-1:0] q_val  [DEPTH];
  logic [DEPTH-1:0]    q_vld;
  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count, count_nxt;
  logic [WW-1:0]       wait_cnt, wait_nxt;
  logic                wb_take, pop, byp, acc, enq;

  assign buf_count  = count;
  assign pipe_stall = (state == DRAIN);
  assign mdu_ready  = (count < CW'(DEPTH));
  assign acc        = mdu_valid & mdu_ready & ~rst;
  assign wb_take    = ~rst & wb_en & ~pipe_stall & (wb_dest != '0);
  assign pop        = ~rst & ~wb_take & (count != '0);
`ifdef RF_ARB_BYPASS_EN
  assign byp        = acc & ~wb_take & (count == '0) & (mdu_dest != '0);
`else
  assign byp        = 1'b0;
`endif
  // dest 0 results complete the handshake but are dropped here
  assign enq        = acc & (mdu_dest != '0) & ~byp;
  assign count_nxt  = count + CW'(enq) - CW'(pop);

  always_comb begin
    wait_nxt = wait_cnt;
    if (pop || count == '0)
      wait_nxt = '0;
    else if (wait_cnt < WW'(MAX_WAIT))
      wait_nxt = wait_cnt + 1'b1;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_dest = '0;
    wr_val  = '0;
    if (wb_take) begin
      wr_en   = 1'b1;
      wr_dest = wb_dest;
      wr_val  = wb_val;
    end else if (pop) begin
      wr_en   = 1'b1;
      wr_dest = q_dest[rd_ptr];
      wr_val  = q_val[rd_ptr];
    end else if (byp) begin
      wr_en   = 1'b1;
      wr_dest = mdu_dest;
      wr_val  = mdu_val;
    end
  end

  // the head being popped this cycle is still valid, so it still flags
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i] && src1 != '0 && q_dest[i] == src1) hazard1 = 1'b1;
      if (q_vld[i] && src2 != '0 && q_dest[i] == src2) hazard2 = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      wait_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      q_vld    <= '0;
    end else begin
      count    <= count_nxt;
      wait_cnt <= wait_nxt;
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (enq) begin
        q_vld[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      case (state)
        IDLE:    if (enq) state <= QUEUED;
        QUEUED: begin
          if (count_nxt == '0)                 state <= IDLE;
          else if (wait_nxt == WW'(MAX_WAIT))  state <= DRAIN;
        end
        DRAIN:   state <= (count_nxt != '0) ? QUEUED : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_dest[wr_ptr] <= mdu_dest;
      q_val[wr_ptr]  <= mdu_val;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: queue-based reference model feeding a scoreboard, checked by a negedge monitor.
module tb_rf_write_arbiter;
  localparam int WORD_LEN = 32;
  localparam int ADDR_LEN = 5;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 3;

  typedef struct packed {
    logic [ADDR_LEN-1:0] dest;
    logic [WORD_LEN-1:0] val;
  } wr_t;

  logic                   clk, rst;
  logic                   wb_en, mdu_valid, mdu_ready;
  logic [ADDR_LEN-1:0]    wb_dest, mdu_dest, src1, src2, wr_dest;
  logic [WORD_LEN-1:0]    wb_val, mdu_val, wr_val;
  logic                   hazard1, hazard2, pipe_stall, wr_en;
  logic [$clog2(DEPTH):0] buf_count;

  rf_write_arbiter #(.WORD_LEN(WORD_LEN), .ADDR_LEN(ADDR_LEN), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_val(wb_val),
    .mdu_valid(mdu_valid), .mdu_dest(mdu_dest), .mdu_val(mdu_val), .mdu_ready(mdu_ready),
    .src1(src1), .src2(src2), .hazard1(hazard1), .hazard2(hazard2),
    .pipe_stall(pipe_stall), .wr_en(wr_en), .wr_dest(wr_dest), .wr_val(wr_val),
    .buf_count(buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  wr_t mq[$];
  wr_t sb[$];
  int  mwait = 0;
  bit  pend = 0;
  logic [ADDR_LEN-1:0] pend_dest;
  logic [WORD_LEN-1:0] pend_val;

  // expectations for the current cycle
  bit exp_wr_en, exp_ready, exp_stall, exp_h1, exp_h2;
  int exp_buf;
  bit mon_en = 0;
  wr_t mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one clock cycle of stimulus; the model predicts everything the DUT shows this cycle
  task automatic step(input bit wbe, input logic [ADDR_LEN-1:0] wbd, input logic [WORD_LEN-1:0] wbv,
                      input bit off, input logic [ADDR_LEN-1:0] od, input logic [WORD_LEN-1:0] ov,
                      input logic [ADDR_LEN-1:0] s1, input logic [ADDR_LEN-1:0] s2);
    bit acc, popped, byp;
    @(posedge clk);
    #1;
    if (!pend && off) begin
      pend = 1; pend_dest = od; pend_val = ov;
    end
    wb_en = wbe; wb_dest = wbd; wb_val = wbv;
    mdu_valid = pend; mdu_dest = pend_dest; mdu_val = pend_val;
    src1 = s1; src2 = s2;

    exp_buf   = mq.size();
    exp_ready = (mq.size() < DEPTH);
    exp_stall = (mwait == MAX_WAIT);
    exp_h1 = 0; exp_h2 = 0;
    foreach (mq[i]) begin
      if (s1 != 0 && mq[i].dest == s1) exp_h1 = 1;
      if (s2 != 0 && mq[i].dest == s2) exp_h2 = 1;
    end
    acc = pend && exp_ready;
    popped = 0; byp = 0; exp_wr_en = 0;
    if (wbe && !exp_stall && wbd != 0) begin
      exp_wr_en = 1; sb.push_back('{dest: wbd, val: wbv});
    end else if (mq.size() > 0) begin
      exp_wr_en = 1; sb.push_back(mq.pop_front()); popped = 1;
    end
`ifdef RF_ARB_BYPASS_EN
    else if (acc && pend_dest != 0) begin
      exp_wr_en = 1; byp = 1; sb.push_back('{dest: pend_dest, val: pend_val});
    end
`endif
    if (acc && pend_dest != 0 && !byp) mq.push_back('{dest: pend_dest, val: pend_val});
    if (popped || exp_buf == 0) mwait = 0;
    else if (mwait < MAX_WAIT) mwait++;
    if (acc) pend = 0;
    mon_en = 1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (mq.size() == 0 && !pend) break;
      step(0, 0, 0, 0, 0, 0, 0, 0);
    end
    chk("drain_timeout", 64'(mq.size()) + 64'(pend), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("buf_count", buf_count, exp_buf);
      chk("mdu_ready", mdu_ready, exp_ready);
      chk("pipe_stall", pipe_stall, exp_stall);
      chk("hazard1", hazard1, exp_h1);
      chk("hazard2", hazard2, exp_h2);
      chk("wr_en", wr_en, exp_wr_en);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        if (wr_en) begin
          chk("wr_dest", wr_dest, mon_e.dest);
          chk("wr_val", wr_val, mon_e.val);
        end
      end
      if (wr_en) chk("wr_dest_zero", (wr_dest == 0), 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; wb_en = 0; wb_dest = 0; wb_val = 0;
    mdu_valid = 0; mdu_dest = 0; mdu_val = 0; src1 = 3; src2 = 4;
    #1;
    chk("rst_buf_count", buf_count, 0);
    chk("rst_mdu_ready", mdu_ready, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_pipe_stall", pipe_stall, 0);
    chk("rst_hazard1", hazard1, 0);
    chk("rst_hazard2", hazard2, 0);
    #21 rst = 0;

    // idle port: single MDU result
    step(0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);
    drain();

    // fill under continuous WB traffic
    for (int i = 0; i < 10; i++) step(1, 3, $urandom, 1, 5'(1 + i), $urandom, 5'(1 + i), 3);
    drain();

    // starvation with one buffered entry
    step(1, 3, 32'h111, 1, 6, 32'h600, 6, 0);
    for (int i = 0; i < 6; i++) step(1, 3, 32'h200 + i, 0, 0, 0, 6, 0);
    drain();

    // register 0 on both sides
    step(1, 0, 32'h1, 1, 0, 32'h2, 0, 0);
    step(1, 0, 32'h3, 0, 0, 0, 0, 0);
    step(1, 3, 32'h4, 1, 4, 32'h44, 4, 0);
    step(1, 0, 32'h5, 0, 0, 0, 4, 0);
    step(0, 0, 0, 0, 0, 0, 4, 0);
    drain();

    // hazard on buffered dests {7, 9}
    step(1, 3, 32'h10, 1, 7, 32'h70, 9, 0);
    step(1, 3, 32'h11, 1, 9, 32'h90, 9, 0);
    step(1, 3, 32'h12, 0, 0, 0, 9, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 9, 7);
    drain();

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    drain();

    // reset mid-operation with two entries buffered
    step(1, 3, 32'h31, 1, 11, 32'hB0, 11, 0);
    step(1, 3, 32'h32, 1, 12, 32'hC0, 11, 0);
    @(posedge clk);
    #1;
    mon_en = 0;
    wb_en = 1; wb_dest = 3; mdu_valid = 0; src1 = 11; src2 = 12;
    #1;
    chk("pre_rst_buf_count", buf_count, 2);
    chk("pre_rst_hazard1", hazard1, 1);
    rst = 1;
    #1;
    chk("midrst_buf_count", buf_count, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_mdu_ready", mdu_ready, 1);
    chk("midrst_hazard1", hazard1, 0);
    chk("midrst_hazard2", hazard2, 0);
    chk("midrst_pipe_stall", pipe_stall, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("inrst_wr_en", wr_en, 0);
      chk("inrst_buf_count", buf_count, 0);
    end
    @(posedge clk);
    #1;
    rst = 0; wb_en = 0;
    mq.delete(); sb.delete(); mwait = 0; pend = 0;
    exp_buf = 0; exp_ready = 1; exp_stall = 0; exp_h1 = 0; exp_h2 = 0; exp_wr_en = 0;
    mon_en = 1;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 11, 12);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
